// File: rtl/core_lsu.sv
// core_lsu: single-outstanding RISC-V load/store unit in front of a simple
// valid/ready data bus with a separate completion (RVALID) channel.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When it is defined,
// misaligned accesses are executed, in two bus beats if they cross a bus
// word. When it is undefined, misaligned accesses complete with an error.
module core_lsu #(
  parameter int DATA_W = 32
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic                REQ_VALID,
  output logic                REQ_READY,
  input  logic                REQ_WE,
  input  logic [2:0]          REQ_FUNCT3,
  input  logic [DATA_W-1:0]   REQ_ADDR,
  input  logic [DATA_W-1:0]   REQ_WDATA,
  input  logic [4:0]          REQ_RD,
  output logic                RSP_VALID,
  output logic [DATA_W-1:0]   RSP_RDATA,
  output logic [4:0]          RSP_RD,
  output logic                RSP_ERR,
  output logic                DMEM_VALID,
  input  logic                DMEM_READY,
  output logic                DMEM_WE,
  output logic [DATA_W-1:0]   DMEM_ADDR,
  output logic [DATA_W/8-1:0] DMEM_WSTRB,
  output logic [DATA_W-1:0]   DMEM_WDATA,
  input  logic                DMEM_RVALID,
  input  logic [DATA_W-1:0]   DMEM_RDATA,
  input  logic                DMEM_ERR
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);

  typedef enum logic [2:0] {IDLE, BEAT, WAIT, BEAT2, WAIT2, RESP} state_t;

  state_t              state;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [LB-1:0]       off_q;
  logic [DATA_W-1:0]   base_q;
  logic                split_q;
  logic [NB-1:0]       strb2_q;
  logic [DATA_W-1:0]   wdata2_q;
  logic [DATA_W-1:0]   rbuf_q;

  logic [LB-1:0]       off;
  logic [DATA_W-1:0]   base;
  int                  sz;
  logic                legal;
  logic                bad;
  logic                split;
  logic [2*NB-1:0]     strb_w;
  logic [2*DATA_W-1:0] wd_w;
  logic [2*DATA_W-1:0] cat;
  logic [DATA_W-1:0]   ld_raw;
  logic [DATA_W-1:0]   ld_data;

  assign off  = REQ_ADDR[LB-1:0];
  assign base = {REQ_ADDR[DATA_W-1:LB], {LB{1'b0}}};

  // Sign- or zero-extend the low (8 << f3[1:0]) bits; f3[2] selects unsigned.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [2:0] f3);
    logic [DATA_W-1:0] r;
    int  bits;
    logic s;
    bits = 8 << f3[1:0];
    s    = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (i == bits - 1) s = d[i] & ~f3[2];
    for (int i = 0; i < DATA_W; i++)
      r[i] = (i < bits) ? d[i] : s;
    return r;
  endfunction

  // Decode the incoming request: legality, alignment, and the lane-shifted
  // strobes/data spanning two bus words (upper half feeds the second beat).
  always_comb begin
    sz     = 1 << REQ_FUNCT3[1:0];
    legal  = 1'b0;
    strb_w = '0;
    wd_w   = '0;
    case (REQ_FUNCT3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b011:                 legal = (DATA_W == 64);
      3'b100, 3'b101:         legal = !REQ_WE;
      3'b110:                 legal = !REQ_WE && (DATA_W == 64);
      default:                legal = 1'b0;
    endcase
`ifdef LSU_MISALIGN_SPLIT_EN
    bad   = !legal;
    split = (int'(off) + sz) > NB;
`else
    bad   = !legal || ((int'(off) & (sz - 1)) != 0);
    split = 1'b0;
`endif
    for (int i = 0; i < NB; i++) begin
      strb_w[i] = (i < sz);
      if (i < sz) wd_w[8*i +: 8] = REQ_WDATA[8*i +: 8];
    end
    strb_w = strb_w << off;
    wd_w   = wd_w << {off, 3'b000};
  end

  // Merge returned beat(s) and shift the addressed bytes down to bit 0.
  always_comb begin
    cat     = (state == WAIT2) ? {DMEM_RDATA, rbuf_q} : {{DATA_W{1'b0}}, DMEM_RDATA};
    ld_raw  = DATA_W'(cat >> {off_q, 3'b000});
    ld_data = extend(ld_raw, f3_q);
  end

  // Request/beat/response sequencer; all outputs are registered here.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      REQ_READY  <= 1'b1;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
      RSP_RD     <= '0;
      RSP_ERR    <= 1'b0;
      DMEM_VALID <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WSTRB <= '0;
      DMEM_WDATA <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      base_q     <= '0;
      split_q    <= 1'b0;
      strb2_q    <= '0;
      wdata2_q   <= '0;
      rbuf_q     <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
      case (state)
        IDLE: if (REQ_VALID) begin
          REQ_READY <= 1'b0;
          we_q      <= REQ_WE;
          f3_q      <= REQ_FUNCT3;
          off_q     <= off;
          base_q    <= base;
          split_q   <= split;
          RSP_RD    <= REQ_RD;
          strb2_q   <= REQ_WE ? strb_w[2*NB-1:NB] : '0;
          wdata2_q  <= REQ_WE ? wd_w[2*DATA_W-1:DATA_W] : '0;
          if (bad) begin
            state     <= RESP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end else begin
            state      <= BEAT;
            DMEM_VALID <= 1'b1;
            DMEM_WE    <= REQ_WE;
            DMEM_ADDR  <= base;
            DMEM_WSTRB <= REQ_WE ? strb_w[NB-1:0] : '0;
            DMEM_WDATA <= REQ_WE ? wd_w[DATA_W-1:0] : '0;
          end
        end
        BEAT: if (DMEM_READY) begin
          DMEM_VALID <= 1'b0;
          state      <= WAIT;
        end
        WAIT: if (DMEM_RVALID) begin
          if (DMEM_ERR) begin
            state     <= RESP;
            RSP_VALID <= 1'b1;
            RSP_ERR   <= 1'b1;
          end else if (split_q) begin
            state      <= BEAT2;
            rbuf_q     <= DMEM_RDATA;
            DMEM_VALID <= 1'b1;
            DMEM_ADDR  <= base_q + DATA_W'(NB);
            DMEM_WSTRB <= strb2_q;
            DMEM_WDATA <= wdata2_q;
          end else begin
            state     <= RESP;
            RSP_VALID <= 1'b1;
            RSP_RDATA <= we_q ? '0 : ld_data;
          end
        end
        BEAT2: if (DMEM_READY) begin
          DMEM_VALID <= 1'b0;
          state      <= WAIT2;
        end
        WAIT2: if (DMEM_RVALID) begin
          state     <= RESP;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= DMEM_ERR;
          RSP_RDATA <= (we_q || DMEM_ERR) ? '0 : ld_data;
        end
        RESP: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed scoreboard bench for core_lsu (DATA_W=32).
// Expected bus beats, memory replies and responses are queued by the stimulus;
// a bus responder and a response monitor pop and compare independently.
module tb_core_lsu;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic          REQ_VALID, REQ_READY, REQ_WE;
  logic [2:0]    REQ_FUNCT3;
  logic [DW-1:0] REQ_ADDR, REQ_WDATA;
  logic [4:0]    REQ_RD;
  logic          RSP_VALID, RSP_ERR;
  logic [DW-1:0] RSP_RDATA;
  logic [4:0]    RSP_RD;
  logic          DMEM_VALID, DMEM_READY, DMEM_WE, DMEM_RVALID, DMEM_ERR;
  logic [DW-1:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [NB-1:0] DMEM_WSTRB;

  core_lsu #(.DATA_W(DW)) dut (
    .CLK(CLK), .NRST(NRST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_RD(REQ_RD),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RD(RSP_RD), .RSP_ERR(RSP_ERR),
    .DMEM_VALID(DMEM_VALID), .DMEM_READY(DMEM_READY), .DMEM_WE(DMEM_WE),
    .DMEM_ADDR(DMEM_ADDR), .DMEM_WSTRB(DMEM_WSTRB), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA), .DMEM_ERR(DMEM_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic we; logic [DW-1:0] addr; logic [NB-1:0] strb; logic [DW-1:0] wdata; } beat_t;
  typedef struct { logic [DW-1:0] data; logic err; } mem_t;
  typedef struct { logic [DW-1:0] rdata; logic err; logic [4:0] rd; int lat; } rsp_t;

  beat_t beat_q[$];
  mem_t  mem_q[$];
  rsp_t  rsp_q[$];
  int total = 0, passed = 0;
  int cyc = 0, acc_cyc = 0, stall = 0, edges = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  task automatic exp_beat(input logic we, input logic [DW-1:0] a, input logic [NB-1:0] s, input logic [DW-1:0] d);
    beat_t b;
    b.we = we; b.addr = a; b.strb = s; b.wdata = d;
    beat_q.push_back(b);
  endtask

  task automatic exp_mem(input logic [DW-1:0] d, input logic e);
    mem_t m;
    m.data = d; m.err = e;
    mem_q.push_back(m);
  endtask

  task automatic exp_rsp(input logic [DW-1:0] d, input logic e, input logic [4:0] rd, input int lat);
    rsp_t r;
    r.rdata = d; r.err = e; r.rd = rd; r.lat = lat;
    rsp_q.push_back(r);
  endtask

  // Bus responder: checks each handshaken beat, replies the following cycle.
  initial begin
    logic hs;
    mem_t m;
    beat_t b;
    DMEM_READY = 1'b0; DMEM_RVALID = 1'b0; DMEM_ERR = 1'b0; DMEM_RDATA = '0;
    forever begin
      @(posedge CLK);
      hs = DMEM_VALID && DMEM_READY && NRST;
      if (hs) begin
        if (beat_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got addr 0x%0h expected no beat (t=%0t)", DMEM_ADDR, $time);
        end else begin
          b = beat_q.pop_front();
          chk("beat_we", 64'(DMEM_WE), 64'(b.we));
          chk("beat_addr", 64'(DMEM_ADDR), 64'(b.addr));
          chk("beat_wstrb", 64'(DMEM_WSTRB), 64'(b.strb));
          chk("beat_wdata", 64'(DMEM_WDATA), 64'(b.wdata));
        end
      end
      #1;
      DMEM_RVALID = hs; DMEM_ERR = 1'b0; DMEM_RDATA = '0;
      if (hs && mem_q.size() != 0) begin
        m = mem_q.pop_front();
        DMEM_RDATA = m.data; DMEM_ERR = m.err;
      end
      if (DMEM_VALID && NRST) begin
        if (stall > 0) begin DMEM_READY = 1'b0; stall--; end
        else DMEM_READY = 1'b1;
      end else DMEM_READY = 1'b0;
    end
  end

  // Response monitor: pops the scoreboard on every RSP_VALID pulse.
  initial begin
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (NRST) begin
        if (RSP_VALID) begin
          if (rsp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_rsp: got rdata 0x%0h err %0b expected no response (t=%0t)", RSP_RDATA, RSP_ERR, $time);
          end else begin
            r = rsp_q.pop_front();
            chk("rsp_rdata", 64'(RSP_RDATA), 64'(r.rdata));
            chk("rsp_err", 64'(RSP_ERR), 64'(r.err));
            chk("rsp_rd", 64'(RSP_RD), 64'(r.rd));
            if (r.lat >= 0) chk("rsp_latency", 64'(cyc - acc_cyc), 64'(r.lat));
          end
        end else begin
          chk("rsp_idle_zero", {31'b0, RSP_ERR, RSP_RDATA}, 64'b0);
        end
      end
    end
  end

  // Present a request and wait (bounded) for the accept edge.
  task automatic req(input logic we, input logic [2:0] f3, input logic [DW-1:0] a,
                     input logic [DW-1:0] wd, input logic [4:0] rd, output int n);
    logic acc;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = a; REQ_WDATA = wd; REQ_RD = rd;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(posedge CLK);
      n++;
      if (REQ_READY) acc = 1'b1;
    end
    #1;
    REQ_VALID = 1'b0;
    acc_cyc = cyc;
    if (!acc) begin total++; $display("FAIL accept_timeout: got no accept expected accept within 50 cycles"); end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < 60) begin @(negedge CLK); n++; end
    chk("rsp_drained", 64'(rsp_q.size()), 64'd0);
    chk("beats_drained", 64'(beat_q.size()), 64'd0);
    rsp_q.delete(); beat_q.delete(); mem_q.delete();
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [DW-1:0] a,
                     input logic [DW-1:0] wd, input logic [4:0] rd);
    int n;
    req(we, f3, a, wd, rd, n);
    wait_rsp();
  endtask

  initial begin
    REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = '0; REQ_ADDR = '0; REQ_WDATA = '0; REQ_RD = '0;
    #12;
    chk("reset_req_ready", 64'(REQ_READY), 64'd1);
    chk("reset_dmem_valid", 64'(DMEM_VALID), 64'd0);
    chk("reset_rsp_valid", 64'(RSP_VALID), 64'd0);
    chk("reset_rsp_data", {31'b0, RSP_ERR, RSP_RDATA}, 64'd0);
    chk("reset_dmem_bus", {28'b0, DMEM_WSTRB, DMEM_ADDR}, 64'd0);
    @(negedge CLK);
    NRST = 1'b1;

    // LW 0x100, first edge after reset, zero-wait: RSP two edges after accept
    exp_beat(0, 32'h100, 4'b0000, 0); exp_mem(32'hDEADBEEF, 0); exp_rsp(32'hDEADBEEF, 0, 5'd5, 2);
    req(0, 3'b010, 32'h100, 0, 5'd5, edges);
    chk("first_accept_edge", 64'(edges), 64'd1);
    wait_rsp();

    // LB / LBU 0x103 on 0x80FF0000
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h80FF0000, 0); exp_rsp(32'hFFFFFF80, 0, 5'd1, 2);
    run(0, 3'b000, 32'h103, 0, 5'd1);
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h80FF0000, 0); exp_rsp(32'h00000080, 0, 5'd2, 2);
    run(0, 3'b100, 32'h103, 0, 5'd2);
    // LH 0x102 / LHU 0x100 on 0x80017F00
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h80017F00, 0); exp_rsp(32'hFFFF8001, 0, 5'd3, 2);
    run(0, 3'b001, 32'h102, 0, 5'd3);
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h80017F00, 0); exp_rsp(32'h00007F00, 0, 5'd4, 2);
    run(0, 3'b101, 32'h100, 0, 5'd4);

    // Stores: SH 0x102, SB 0x101, SW 0x200
    exp_beat(1, 32'h100, 4'b1100, 32'hABCD0000); exp_mem(0, 0); exp_rsp(0, 0, 5'd6, 2);
    run(1, 3'b001, 32'h102, 32'h1234ABCD, 5'd6);
    exp_beat(1, 32'h100, 4'b0010, 32'h00005A00); exp_mem(0, 0); exp_rsp(0, 0, 5'd7, 2);
    run(1, 3'b000, 32'h101, 32'hFFFFFF5A, 5'd7);
    exp_beat(1, 32'h200, 4'b1111, 32'hCAFEF00D); exp_mem(0, 0); exp_rsp(0, 0, 5'd8, 2);
    run(1, 3'b010, 32'h200, 32'hCAFEF00D, 5'd8);

    // Illegal funct3: LD on 32-bit, 111 load, 100 store -> error, no beat
    exp_rsp(0, 1, 5'd9, 0);  run(0, 3'b011, 32'h100, 0, 5'd9);
    exp_rsp(0, 1, 5'd10, 0); run(0, 3'b111, 32'h100, 0, 5'd10);
    exp_rsp(0, 1, 5'd11, 0); run(1, 3'b100, 32'h100, 32'h1, 5'd11);

    // Bus error on aligned load
    exp_beat(0, 32'h300, 0, 0); exp_mem(32'h12345678, 1); exp_rsp(0, 1, 5'd12, 2);
    run(0, 3'b010, 32'h300, 0, 5'd12);

`ifdef LSU_MISALIGN_SPLIT_EN
    // LW 0x101 crosses a word: two beats, merged data
    exp_beat(0, 32'h100, 0, 0); exp_beat(0, 32'h104, 0, 0);
    exp_mem(32'h44332211, 0); exp_mem(32'h88776655, 0); exp_rsp(32'h55443322, 0, 5'd13, 4);
    run(0, 3'b010, 32'h101, 0, 5'd13);
    // LH 0x101 stays inside one word: single beat
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h44332211, 0); exp_rsp(32'h00003322, 0, 5'd14, 2);
    run(0, 3'b001, 32'h101, 0, 5'd14);
    // SW 0x103 split store with per-beat strobes
    exp_beat(1, 32'h100, 4'b1000, 32'h44000000); exp_beat(1, 32'h104, 4'b0111, 32'h00112233);
    exp_mem(0, 0); exp_mem(0, 0); exp_rsp(0, 0, 5'd15, 4);
    run(1, 3'b010, 32'h103, 32'h11223344, 5'd15);
    // LH 0xFFFFFFFF wraps to address 0 for the second beat
    exp_beat(0, 32'hFFFFFFFC, 0, 0); exp_beat(0, 32'h0, 0, 0);
    exp_mem(32'hAB000000, 0); exp_mem(32'h000000CD, 0); exp_rsp(32'hFFFFCDAB, 0, 5'd16, 4);
    run(0, 3'b001, 32'hFFFFFFFF, 0, 5'd16);
    // Error on first beat of a split load: no second beat
    exp_beat(0, 32'h100, 0, 0); exp_mem(32'h0, 1); exp_rsp(0, 1, 5'd17, 2);
    run(0, 3'b010, 32'h102, 0, 5'd17);
`else
    // Misaligned accesses are rejected without touching the bus
    exp_rsp(0, 1, 5'd13, 0); run(0, 3'b010, 32'h101, 0, 5'd13);
    exp_rsp(0, 1, 5'd14, 0); run(1, 3'b001, 32'h101, 32'h5555, 5'd14);
    exp_rsp(0, 1, 5'd15, 0); run(0, 3'b101, 32'h103, 0, 5'd15);
`endif

    // Reset while a beat is stalled: abandoned, no response
    stall = 100;
    req(0, 3'b010, 32'h400, 0, 5'd20, edges);
    repeat (5) @(posedge CLK);
    #1;
    chk("stall_dmem_valid", 64'(DMEM_VALID), 64'd1);
    #2;
    NRST = 1'b0;
    #1;
    chk("async_rst_dmem_valid", 64'(DMEM_VALID), 64'd0);
    chk("async_rst_req_ready", 64'(REQ_READY), 64'd1);
    chk("async_rst_rsp_valid", 64'(RSP_VALID), 64'd0);
    stall = 0;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
    chk("release_req_ready", 64'(REQ_READY), 64'd1);
    exp_beat(0, 32'h500, 0, 0); exp_mem(32'h0BADF00D, 0); exp_rsp(32'h0BADF00D, 0, 5'd21, 2);
    req(0, 3'b010, 32'h500, 0, 5'd21, edges);
    chk("post_rst_accept_edge", 64'(edges), 64'd1);
    wait_rsp();

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
